// File: rtl/l2_config_and_types.sv
// Shared types and counter widths for the L2 AXI read/write scheduler.
package l2_config_and_types;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_WR_RESP
    } sched_state_t;

    localparam int STREAK_W = 8;
    localparam int OUTST_W  = 8;
    localparam int BEAT_W   = 5;

    // Saturating increment used by the fairness streak counters.
    function automatic logic [STREAK_W-1:0] streak_next(
        input logic [STREAK_W-1:0] cur,
        input logic [STREAK_W-1:0] limit
    );
        return (cur >= limit) ? limit : cur + STREAK_W'(1);
    endfunction

endpackage

// File: rtl/l2_axi_rw_scheduler.sv
// Arbitrates L2 read and write burst requests onto one AXI master port.
// Define L2_AXI_STARVATION_GUARD_EN to build the read/write streak fairness guard.
module l2_axi_rw_scheduler
    import l2_config_and_types::*;
#(
    parameter int BURST_LEN             = 8,
    parameter int READ_COUNTER_MAX      = 5,
    parameter int WRITE_COUNTER_MAX     = 5,
    parameter int MAX_OUTSTANDING_READS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_valid,
    input  logic [31:0] rd_addr,
    output logic        rd_ready,
    input  logic        wr_valid,
    input  logic [31:0] wr_addr,
    output logic        wr_ready,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    output logic [31:0] axi_araddr,
    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [31:0] axi_awaddr,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    output logic        axi_wlast,
    input  logic        axi_bvalid,
    output logic        axi_bready,
    input  logic        axi_rlast_hs
);

    if (BURST_LEN < 1 || BURST_LEN > 16 || (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_bad_burst_len
        $error("BURST_LEN must be a power of two between 1 and 16");
    end
    if (READ_COUNTER_MAX < 1 || READ_COUNTER_MAX >= 2**STREAK_W ||
        WRITE_COUNTER_MAX < 1 || WRITE_COUNTER_MAX >= 2**STREAK_W) begin : g_bad_streak_max
        $error("streak limits must fit the streak counter width and be at least 1");
    end
    if (MAX_OUTSTANDING_READS < 1 || MAX_OUTSTANDING_READS >= 2**OUTST_W) begin : g_bad_outstanding
        $error("MAX_OUTSTANDING_READS must fit the outstanding counter width");
    end

    sched_state_t        state;
    sched_state_t        next_state;
    logic [OUTST_W-1:0]  outstanding;
    logic [BEAT_W-1:0]   beat_cnt;
    logic                read_room;
    logic                grant_rd;
    logic                grant_wr;
    logic                w_hs;
    logic                last_beat;
    logic                rlast_dec;

    assign read_room = outstanding < OUTST_W'(MAX_OUTSTANDING_READS);
    assign last_beat = beat_cnt == BEAT_W'(BURST_LEN - 1);
    assign w_hs      = (state == ST_WR_DATA) && wdata_valid && axi_wready;
    assign rlast_dec = axi_rlast_hs && (outstanding != '0);

`ifdef L2_AXI_STARVATION_GUARD_EN
    logic [STREAK_W-1:0] read_streak;
    logic [STREAK_W-1:0] write_streak;
    logic                wr_forced;
    logic                rd_forced;

    assign wr_forced = wr_valid && (read_streak == STREAK_W'(READ_COUNTER_MAX));
    assign rd_forced = rd_valid && (write_streak == STREAK_W'(WRITE_COUNTER_MAX));
    assign grant_rd  = (state == ST_IDLE) && rd_valid && read_room && (!wr_forced || rd_forced);

    // A streak only grows while the other side is actually waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_streak  <= '0;
            write_streak <= '0;
        end else if (grant_rd) begin
            write_streak <= '0;
            if (wr_valid) begin
                read_streak <= streak_next(read_streak, STREAK_W'(READ_COUNTER_MAX));
            end
        end else if (grant_wr) begin
            read_streak <= '0;
            if (rd_valid) begin
                write_streak <= streak_next(write_streak, STREAK_W'(WRITE_COUNTER_MAX));
            end
        end
    end
`else
    assign grant_rd = (state == ST_IDLE) && rd_valid && read_room;
`endif

    assign grant_wr = (state == ST_IDLE) && !grant_rd && wr_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        rd_ready    = 1'b0;
        wr_ready    = 1'b0;
        wdata_ready = 1'b0;
        axi_arvalid = 1'b0;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_wlast   = 1'b0;
        axi_bready  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_rd) begin
                    next_state = ST_RD_ADDR;
                end else if (grant_wr) begin
                    next_state = ST_WR_ADDR;
                end
            end
            ST_RD_ADDR: begin
                axi_arvalid = 1'b1;
                rd_ready    = axi_arready;
                if (axi_arready) begin
                    next_state = ST_IDLE;
                end
            end
            ST_WR_ADDR: begin
                axi_awvalid = 1'b1;
                wr_ready    = axi_awready;
                if (axi_awready) begin
                    next_state = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                axi_wvalid  = wdata_valid;
                wdata_ready = w_hs;
                axi_wlast   = last_beat;
                if (w_hs && last_beat) begin
                    next_state = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                axi_bready = 1'b1;
                if (axi_bvalid) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Addresses are captured at grant time so the requester may move on after its ready pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            axi_araddr <= '0;
            axi_awaddr <= '0;
        end else if (grant_rd) begin
            axi_araddr <= rd_addr;
        end else if (grant_wr) begin
            axi_awaddr <= wr_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else if (rd_ready && !rlast_dec) begin
            outstanding <= outstanding + OUTST_W'(1);
        end else if (!rd_ready && rlast_dec) begin
            outstanding <= outstanding - OUTST_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (w_hs) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
        end
    end

endmodule

// File: tb/tb_l2_axi_rw_scheduler.sv
// Scoreboard bench for l2_axi_rw_scheduler: expected grants and W beats are queued, a monitor checks them.
module tb_l2_axi_rw_scheduler;

    localparam int BURST = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_valid;
    logic [31:0] rd_addr;
    logic        rd_ready;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic        wr_ready;
    logic        wdata_valid;
    logic        wdata_ready;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_araddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_awaddr;
    logic        axi_wvalid;
    logic        axi_wready;
    logic        axi_wlast;
    logic        axi_bvalid;
    logic        axi_bready;
    logic        axi_rlast_hs;

    always #5 clk = ~clk;

    l2_axi_rw_scheduler #(
        .BURST_LEN(BURST),
        .READ_COUNTER_MAX(5),
        .WRITE_COUNTER_MAX(5),
        .MAX_OUTSTANDING_READS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rd_valid(rd_valid),
        .rd_addr(rd_addr),
        .rd_ready(rd_ready),
        .wr_valid(wr_valid),
        .wr_addr(wr_addr),
        .wr_ready(wr_ready),
        .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready),
        .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready),
        .axi_araddr(axi_araddr),
        .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready),
        .axi_awaddr(axi_awaddr),
        .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready),
        .axi_rlast_hs(axi_rlast_hs)
    );

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
    } exp_t;

    exp_t        addr_q[$];
    logic        wlast_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rd_addr = 32'h1000_0000;
    logic [31:0] exp_wr_addr = 32'h2000_0000;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout required completion", name);
    endtask

    task automatic pushRead();
        exp_t e;
        e.is_write = 1'b0;
        e.addr     = exp_rd_addr;
        addr_q.push_back(e);
        exp_rd_addr = exp_rd_addr + 32'h40;
    endtask

    // Queues the AW grant plus the wlast value expected on each of the first 'beats' W beats.
    task automatic pushWrite(input int beats);
        exp_t e;
        e.is_write = 1'b1;
        e.addr     = exp_wr_addr;
        addr_q.push_back(e);
        exp_wr_addr = exp_wr_addr + 32'h100;
        for (int i = 0; i < beats; i++) begin
            wlast_q.push_back(i == BURST - 1);
        end
    endtask

    // Holds requests until n_rd reads and n_wr writes are accepted; optionally retires each read a cycle later.
    task automatic applyStimulus(input int n_rd, input int n_wr, input bit rlast_after_rd,
                                 input bit keep_rd, input int budget);
        int   nrd = 0;
        int   nwr = 0;
        int   cyc = 0;
        logic got_rd;
        logic got_wr;
        rd_valid = (n_rd > 0);
        wr_valid = (n_wr > 0);
        while ((nrd < n_rd || nwr < n_wr) && cyc < budget) begin
            @(negedge clk);
            got_rd = rd_ready;
            got_wr = wr_ready;
            @(posedge clk);
            #1;
            axi_rlast_hs = 1'b0;
            if (got_rd) begin
                nrd++;
                rd_addr = rd_addr + 32'h40;
                if (rlast_after_rd) axi_rlast_hs = 1'b1;
                if (nrd >= n_rd && !keep_rd) rd_valid = 1'b0;
            end
            if (got_wr) begin
                nwr++;
                wr_addr = wr_addr + 32'h100;
                if (nwr >= n_wr) wr_valid = 1'b0;
            end
            cyc++;
        end
        if (axi_rlast_hs) begin
            @(posedge clk);
            #1;
            axi_rlast_hs = 1'b0;
        end
        if (!keep_rd) rd_valid = 1'b0;
        wr_valid = 1'b0;
        if (cyc >= budget) failNow("traffic_budget");
    endtask

    task automatic pulseRlast(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            axi_rlast_hs = 1'b1;
        end
        @(posedge clk);
        #1;
        axi_rlast_hs = 1'b0;
    endtask

    function automatic logic [7:0] ctrlOutputs();
        return {rd_ready, wr_ready, wdata_ready, axi_arvalid, axi_awvalid, axi_wvalid, axi_wlast, axi_bready};
    endfunction

    initial begin : monitor
        exp_t        e;
        logic        obs_w;
        logic [31:0] obs_addr;
        logic        exp_last;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if ((axi_arvalid && axi_arready) || (axi_awvalid && axi_awready)) begin
                    obs_w    = axi_awvalid && axi_awready;
                    obs_addr = obs_w ? axi_awaddr : axi_araddr;
                    if (obs_w) checkOutput("wr_ready_pulse", 64'(wr_ready), 64'd1);
                    else checkOutput("rd_ready_pulse", 64'(rd_ready), 64'd1);
                    if (addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_grant: got write=%0d addr=%h required no grant", obs_w, obs_addr);
                    end else begin
                        e = addr_q.pop_front();
                        checkOutput("grant_order", 64'({obs_w, obs_addr}), 64'({e.is_write, e.addr}));
                    end
                end
                if (axi_wvalid && axi_wready) begin
                    checkOutput("wdata_ready", 64'(wdata_ready), 64'd1);
                    if (wlast_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_beat: got wlast=%0d required no beat", axi_wlast);
                    end else begin
                        exp_last = wlast_q.pop_front();
                        checkOutput("wlast", 64'(axi_wlast), 64'(exp_last));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got no finish required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int   beats;
        int   cyc;
        logic got;
        logic seen_b;

        rst          = 1'b1;
        rd_valid     = 1'b0;
        rd_addr      = 32'h1000_0000;
        wr_valid     = 1'b0;
        wr_addr      = 32'h2000_0000;
        wdata_valid  = 1'b0;
        axi_arready  = 1'b0;
        axi_awready  = 1'b0;
        axi_wready   = 1'b0;
        axi_bvalid   = 1'b0;
        axi_rlast_hs = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_ctrl", 64'(ctrlOutputs()), 64'd0);
        checkOutput("reset_araddr", 64'(axi_araddr), 64'd0);
        checkOutput("reset_awaddr", 64'(axi_awaddr), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_ctrl", 64'(ctrlOutputs()), 64'd0);

        $display("[TB] phase 1: both requesters saturated, reads retired promptly");
        @(posedge clk);
        #1;
        axi_arready = 1'b1;
        axi_awready = 1'b1;
        wdata_valid = 1'b1;
        axi_wready  = 1'b1;
        axi_bvalid  = 1'b1;
`ifdef L2_AXI_STARVATION_GUARD_EN
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) pushRead();
            pushWrite(BURST);
        end
        applyStimulus(10, 2, 1'b1, 1'b0, 400);
`else
        for (int i = 0; i < 6; i++) pushRead();
        pushWrite(BURST);
        applyStimulus(6, 1, 1'b1, 1'b0, 400);
`endif
        repeat (15) @(posedge clk);

        $display("[TB] phase 2: outstanding limit blocks reads, writes fill the gap");
        #1;
        for (int i = 0; i < 4; i++) pushRead();
        pushWrite(BURST);
        pushWrite(BURST);
        applyStimulus(4, 2, 1'b0, 1'b1, 400);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("ar_stall", 64'(axi_arvalid), 64'd0);
        end
        pushRead();
        @(posedge clk);
        #1;
        axi_rlast_hs = 1'b1;
        @(negedge clk);
        checkOutput("ar_during_rlast", 64'(axi_arvalid), 64'd0);
        @(posedge clk);
        #1;
        axi_rlast_hs = 1'b0;
        @(negedge clk);
        checkOutput("ar_grant_cycle", 64'(axi_arvalid), 64'd0);
        @(negedge clk);
        checkOutput("ar_after_rlast", 64'(axi_arvalid), 64'd1);
        @(posedge clk);
        #1;
        rd_valid = 1'b0;
        rd_addr  = rd_addr + 32'h40;
        // Two surplus rlast pulses at zero must not wrap the counter.
        pulseRlast(6);
        for (int i = 0; i < 4; i++) pushRead();
        applyStimulus(4, 0, 1'b0, 1'b0, 100);
        pulseRlast(4);
        repeat (3) @(posedge clk);

        $display("[TB] phase 3: write burst with wready toggling");
        #1;
        pushWrite(BURST);
        axi_bvalid = 1'b0;
        axi_wready = 1'b0;
        wr_valid   = 1'b1;
        beats      = 0;
        cyc        = 0;
        seen_b     = 1'b0;
        while (!seen_b && cyc < 200) begin
            @(negedge clk);
            got = wr_ready;
            if (axi_wvalid && axi_wready) beats++;
            if (axi_bready) seen_b = 1'b1;
            @(posedge clk);
            #1;
            if (got) begin
                wr_valid = 1'b0;
                wr_addr  = wr_addr + 32'h100;
            end
            axi_wready = ~axi_wready;
            cyc++;
        end
        if (!seen_b) failNow("bready_wait");
        checkOutput("burst_beats", 64'(beats), 64'd8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bready_hold", 64'(axi_bready), 64'd1);
            checkOutput("wvalid_in_resp", 64'(axi_wvalid), 64'd0);
            @(posedge clk);
            #1;
        end
        axi_bvalid = 1'b1;
        @(posedge clk);
        #1;
        axi_bvalid = 1'b0;
        @(negedge clk);
        checkOutput("bready_released", 64'(axi_bready), 64'd0);

        $display("[TB] phase 4: reset in the middle of a write burst");
        @(posedge clk);
        #1;
        pushWrite(3);
        axi_wready  = 1'b1;
        wdata_valid = 1'b0;
        wr_valid    = 1'b1;
        got         = 1'b0;
        cyc         = 0;
        while (!got && cyc < 50) begin
            @(negedge clk);
            got = wr_ready;
            cyc++;
        end
        if (!got) failNow("aw_wait");
        @(posedge clk);
        #1;
        wr_valid    = 1'b0;
        wr_addr     = wr_addr + 32'h100;
        wdata_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("mid_burst_wvalid", 64'(axi_wvalid), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_ctrl", 64'(ctrlOutputs()), 64'd0);
        checkOutput("rst_araddr", 64'(axi_araddr), 64'd0);
        checkOutput("rst_awaddr", 64'(axi_awaddr), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ctrl", 64'(ctrlOutputs()), 64'd0);
        pushRead();
        @(posedge clk);
        #1;
        rd_valid = 1'b1;
        @(negedge clk);
        checkOutput("ar_latency_req", 64'(axi_arvalid), 64'd0);
        @(negedge clk);
        checkOutput("ar_latency_one", 64'(axi_arvalid), 64'd1);
        @(posedge clk);
        #1;
        rd_valid = 1'b0;
        rd_addr  = rd_addr + 32'h40;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("addr_q_drained", 64'(addr_q.size()), 64'd0);
        checkOutput("wlast_q_drained", 64'(wlast_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_axi_rw_scheduler.md
L2_AXI_RW_SCHEDULER -- requirements
Module: l2_axi_rw_scheduler

Interface
REQ-001 SHALL have parameter BURST_LEN, default 8, beats per write burst (power of 2, 1..16).
REQ-002 SHALL have parameter READ_COUNTER_MAX, default 5, max consecutive read grants while a write waits.
REQ-003 SHALL have parameter WRITE_COUNTER_MAX, default 5, max consecutive write grants while a read waits.
REQ-004 SHALL have parameter MAX_OUTSTANDING_READS, default 4, in-flight AR bursts allowed.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port rd_valid  in  1  read request pending; held until rd_ready.
REQ-008 SHALL have port rd_addr  in  32  read burst address, stable while rd_valid.
REQ-009 SHALL have port rd_ready  out  1  one-cycle pulse: read request accepted by AXI.
REQ-010 SHALL have port wr_valid  in  1  write request pending; held until wr_ready.
REQ-011 SHALL have port wr_addr  in  32  write burst address, stable while wr_valid.
REQ-012 SHALL have port wr_ready  out  1  one-cycle pulse: write address accepted by AXI.
REQ-013 SHALL have port wdata_valid  in  1  write-data FIFO non-empty.
REQ-014 SHALL have port wdata_ready  out  1  pop write-data FIFO.
REQ-015 SHALL have ports axi_arvalid out 1, axi_arready in 1, axi_araddr out 32: AXI read-address channel.
REQ-016 SHALL have ports axi_awvalid out 1, axi_awready in 1, axi_awaddr out 32: AXI write-address channel.
REQ-017 SHALL have ports axi_wvalid out 1, axi_wready in 1, axi_wlast out 1: AXI write-data control.
REQ-018 SHALL have ports axi_bvalid in 1, axi_bready out 1: AXI write response.
REQ-019 SHALL have port axi_rlast_hs  in  1  final R beat handshake (rvalid&rready&rlast).

Function
REQ-020 SHALL implement FSM IDLE, RD_ADDR, WR_ADDR, WR_DATA, WR_RESP; one grant per IDLE cycle.
REQ-021 IDLE: SHALL grant read if rd_valid and outstanding<MAX_OUTSTANDING_READS and not write-forced; else write if wr_valid; registers chosen address into axi_araddr/axi_awaddr.
REQ-022 Write-forced SHALL mean wr_valid and read_streak==READ_COUNTER_MAX; read-forced (read wins over write) SHALL mean rd_valid and write_streak==WRITE_COUNTER_MAX.
REQ-023 read_streak SHALL increment on read grant when wr_valid, clear on write grant; write_streak symmetric; both saturate.
REQ-024 RD_ADDR: axi_arvalid=1 until axi_arready; on handshake rd_ready pulses, outstanding+1, return IDLE.
REQ-025 WR_ADDR: axi_awvalid=1 until axi_awready; on handshake wr_ready pulses, go WR_DATA.
REQ-026 WR_DATA: axi_wvalid=wdata_valid, wdata_ready=wdata_valid&axi_wready; beat counter increments per handshake; axi_wlast=(count==BURST_LEN-1); after last beat go WR_RESP.
REQ-027 WR_RESP: axi_bready=1; on axi_bvalid return IDLE; one write in flight max.
REQ-028 outstanding SHALL decrement on axi_rlast_hs; simultaneous increment and decrement leaves it unchanged; never wraps.
REQ-029 Latency: rd_valid in IDLE to axi_arvalid SHALL be 1 cycle.

Reset
REQ-030 rst SHALL immediately force IDLE, clear streaks, outstanding and beat counter, and drive every output 0; addresses 0; in-flight bursts abandoned.

Configuration
REQ-031 With L2_AXI_STARVATION_GUARD_EN defined, REQ-022/023 SHALL apply; without it, reads SHALL have strict priority and streak counters SHALL not be built.

Structure
REQ-032 FSM state enum and streak/outstanding counter widths SHALL live in l2_config_and_types; no sub-module.

Verification
REQ-033 rd_valid and wr_valid held high continuously, arready=awready=1 -> 5 read grants then 1 write, repeating (guard on).
REQ-034 Same stimulus, guard off -> only reads until outstanding=4, write granted only while read blocked.
REQ-035 4 reads issued, no rlast -> 5th read stalls; one axi_rlast_hs -> 5th AR issued next IDLE cycle.
REQ-036 Write burst with wready toggling every cycle -> exactly 8 W beats, wlast on 8th only, bready after.
REQ-037 rst asserted in WR_DATA mid-burst -> all outputs 0 same cycle, IDLE after release.
